// File: rtl/instr_fetch_queue_if.sv
// Instruction type shared by fetch/align and decode, plus the queue's bundled port interface.
// The package sits in this file so it compiles before the interface and the queue.
package ifq_pkg;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } except_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        except_t     except;
    } aligned_instr_t;

endpackage

interface instr_fetch_queue_if #(
    parameter int DEPTH       = 8,
    parameter int FETCH_WIDTH = 2
);
    import ifq_pkg::*;

    logic                                  i_flush;
    logic                                  i_valid;
    aligned_instr_t [0:FETCH_WIDTH-1]      i_instrs;
    logic                                  o_stall;
    logic                                  i_stall;
    logic                                  o_valid;
    aligned_instr_t [0:FETCH_WIDTH-1]      o_instrs;
    logic [$clog2(DEPTH):0]                o_count;

    // The queue is the slave; the fetch/decode environment is the master.
    modport slave (
        input  i_flush, i_valid, i_instrs, i_stall,
        output o_stall, o_valid, o_instrs, o_count
    );

    modport master (
        output i_flush, i_valid, i_instrs, i_stall,
        input  o_stall, o_valid, o_instrs, o_count
    );

endinterface

// File: rtl/instr_fetch_queue.sv
// Circular instruction buffer between fetch/align and decode: compacts valid slots on
// enqueue, presents up to two in-order instructions, and drops everything on flush.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FETCH_WIDTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    instr_fetch_queue_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    if (FETCH_WIDTH != 2) begin : g_fetch_width_check
        $error("instr_fetch_queue: only FETCH_WIDTH == 2 is supported");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("instr_fetch_queue: DEPTH must be a power of two and at least 4");
    end

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    aligned_instr_t   mem_q [DEPTH];

    logic             enq, deq;
    logic [1:0]       n_enq, n_deq;
    logic [PTR_W-1:0] head_nxt;
    logic [PTR_W-1:0] wr_ptr1;
    aligned_instr_t [0:1] pres;

    // Back-pressure looks only at registered occupancy, so it never waits on decode.
    assign bus.o_stall = (count_q > CNT_W'(DEPTH - 2));
    assign bus.o_valid = (count_q != '0);
    assign bus.o_count = count_q;
    assign bus.o_instrs = pres;

    assign head_nxt = head_q + PTR_ONE;
    assign wr_ptr1  = bus.i_instrs[0].valid ? tail_q + PTR_ONE : tail_q;

    assign enq = bus.i_valid && !bus.o_stall;
    assign deq = bus.o_valid && !bus.i_stall;

    always_comb begin
        // NOTE: every signal gets a default before any condition, so no latch is inferred.
        pres = '0;
        if (count_q >= CNT_W'(1)) begin
            pres[0] = mem_q[head_q];
        end
        // A faulting head instruction is always handed to decode on its own.
        if ((count_q >= CNT_W'(2)) && !mem_q[head_q].except.valid) begin
            pres[1] = mem_q[head_nxt];
        end
    end

    always_comb begin
        n_enq = '0;
        n_deq = '0;
        if (enq) begin
            n_enq = {1'b0, bus.i_instrs[0].valid} + {1'b0, bus.i_instrs[1].valid};
        end
        if (deq) begin
            n_deq = {1'b0, pres[0].valid} + {1'b0, pres[1].valid};
        end
        tail_d  = tail_q + PTR_W'(n_enq);
        head_d  = head_q + PTR_W'(n_deq);
        count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
    end

    // NOTE: reset is synchronous and shares priority with flush; both override enqueue/dequeue.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array has no reset; count_q alone defines which entries are live,
    // so stale contents are never presented.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            if (bus.i_instrs[0].valid) begin
                mem_q[tail_q] <= bus.i_instrs[0];
            end
            if (bus.i_instrs[1].valid) begin
                mem_q[wr_ptr1] <= bus.i_instrs[1];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: stimulus pushes expected instructions into a
// scoreboard queue, and a negedge monitor compares whatever the queue hands to decode.
module tb_instr_fetch_queue;
    import ifq_pkg::*;

    localparam int DEPTH = 8;
    localparam int FW    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_queue_if #(.DEPTH(DEPTH), .FETCH_WIDTH(FW)) bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic aligned_instr_t mk(input logic [31:0] pc, input logic v, input logic exc);
        aligned_instr_t t;
        t              = '0;
        t.valid        = v;
        t.pc           = pc;
        t.instr        = {pc[15:0], 16'h0013};
        t.except.valid = exc;
        t.except.cause = exc ? 4'd2 : 4'd0;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one bundle; 'accept' is the hand-decided outcome for this cycle.
    task automatic drive(input aligned_instr_t s0, input aligned_instr_t s1, input bit accept);
        exp_t e;
        bus.i_valid     = 1'b1;
        bus.i_instrs[0] = s0;
        bus.i_instrs[1] = s1;
        if (accept) begin
            if (s0.valid) begin e.pc = s0.pc; e.exc = s0.except.valid; exp_q.push_back(e); end
            if (s1.valid) begin e.pc = s1.pc; e.exc = s1.except.valid; exp_q.push_back(e); end
        end
    endtask

    task automatic idle();
        bus.i_valid  = 1'b0;
        bus.i_instrs = '0;
    endtask

    // Monitor: peeks the head while decode stalls, pops every instruction decode takes.
    always @(negedge clk) begin
        if (rst_n && !bus.i_flush && bus.o_valid) begin
            if (exp_q.size() == 0) begin
                check("mon_queue_nonempty", 64'd0, 64'd1);
            end else if (bus.i_stall) begin
                check("mon_head_pc", bus.o_instrs[0].pc, exp_q[0].pc);
            end else begin
                for (int k = 0; k < FW; k++) begin
                    if (bus.o_instrs[k].valid) begin
                        if (exp_q.size() == 0) begin
                            check("mon_extra_instr", bus.o_instrs[k].pc, 64'hffff_ffff);
                        end else begin
                            check("mon_pc", bus.o_instrs[k].pc, exp_q[0].pc);
                            check("mon_exc", bus.o_instrs[k].except.valid, exp_q[0].exc);
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_flush  = 1'b0;
        bus.i_stall  = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_valid", bus.o_valid, 0);
        check("rst_count", bus.o_count, 0);
        check("rst_stall", bus.o_stall, 0);
        check("rst_instrs_zero", (bus.o_instrs == '0), 1);

        // Full pair held by decode stall, then released
        bus.i_stall = 1'b1;
        drive(mk(32'h100, 1, 0), mk(32'h104, 1, 0), 1);
        tick();
        idle();
        check("pair_count", bus.o_count, 2);
        check("pair_valid", bus.o_valid, 1);
        check("pair_pc0", bus.o_instrs[0].pc, 32'h100);
        check("pair_pc1", bus.o_instrs[1].pc, 32'h104);
        bus.i_stall = 1'b0;
        tick();
        check("pair_drain_count", bus.o_count, 0);
        check("pair_drain_valid", bus.o_valid, 0);

        // Compaction: only slot 1 valid lands at the tail
        bus.i_stall = 1'b1;
        drive(mk(32'h200, 0, 0), mk(32'h204, 1, 0), 1);
        tick();
        idle();
        check("compact_count", bus.o_count, 1);
        check("compact_pc0", bus.o_instrs[0].pc, 32'h204);
        check("compact_slot1_invalid", bus.o_instrs[1].valid, 0);
        bus.i_stall = 1'b0;
        tick();
        check("compact_drain", bus.o_count, 0);

        // Fill to DEPTH under decode stall
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(mk(32'h300 + 8 * i, 1, 0), mk(32'h304 + 8 * i, 1, 0), 1);
            tick();
        end
        idle();
        check("fill3_count", bus.o_count, 6);
        check("fill3_stall", bus.o_stall, 0);
        drive(mk(32'h318, 1, 0), mk(32'h31c, 1, 0), 1);
        tick();
        check("fill4_count", bus.o_count, 8);
        check("fill4_stall", bus.o_stall, 1);
        drive(mk(32'h400, 1, 0), mk(32'h404, 1, 0), 0);
        tick();
        idle();
        check("full_ignore_count", bus.o_count, 8);
        bus.i_stall = 1'b0;
        tick();
        check("release1_count", bus.o_count, 6);
        check("release1_stall", bus.o_stall, 0);
        tick();
        check("release2_count", bus.o_count, 4);
        tick();
        check("release3_count", bus.o_count, 2);
        tick();
        check("release4_count", bus.o_count, 0);

        // Streaming 2/cycle with decode always ready; pointers wrap several times
        for (int i = 0; i < 20; i++) begin
            drive(mk(32'h500 + 8 * i, 1, 0), mk(32'h504 + 8 * i, 1, 0), 1);
            tick();
            check("stream_count", bus.o_count, 2);
        end
        idle();
        tick();
        check("stream_drain", bus.o_count, 0);

        // Faulting head instruction is presented alone
        bus.i_stall = 1'b1;
        drive(mk(32'h600, 1, 1), mk(32'h604, 1, 0), 1);
        tick();
        drive(mk(32'h608, 1, 0), mk(32'h60c, 0, 0), 1);
        tick();
        idle();
        check("exc_count", bus.o_count, 3);
        check("exc_pc0", bus.o_instrs[0].pc, 32'h600);
        check("exc_slot1_invalid", bus.o_instrs[1].valid, 0);
        bus.i_stall = 1'b0;
        tick();
        check("exc_after_count", bus.o_count, 2);
        check("exc_after_slot1_valid", bus.o_instrs[1].valid, 1);
        check("exc_after_pc1", bus.o_instrs[1].pc, 32'h608);
        tick();
        check("exc_drain", bus.o_count, 0);

        // Flush beats a same-cycle enqueue and dequeue
        bus.i_stall = 1'b1;
        drive(mk(32'h700, 1, 0), mk(32'h704, 1, 0), 1);
        tick();
        drive(mk(32'h708, 1, 0), mk(32'h70c, 1, 0), 1);
        tick();
        drive(mk(32'h710, 1, 0), mk(32'h714, 0, 0), 1);
        tick();
        check("preflush_count", bus.o_count, 5);
        bus.i_flush = 1'b1;
        bus.i_stall = 1'b0;
        drive(mk(32'h720, 1, 0), mk(32'h724, 1, 0), 0);
        tick();
        exp_q.delete();
        bus.i_flush = 1'b0;
        bus.i_stall = 1'b1;
        idle();
        check("flush_count", bus.o_count, 0);
        check("flush_valid", bus.o_valid, 0);
        check("flush_stall", bus.o_stall, 0);
        drive(mk(32'h730, 1, 0), mk(32'h734, 1, 0), 1);
        tick();
        idle();
        check("postflush_count", bus.o_count, 2);
        check("postflush_pc0", bus.o_instrs[0].pc, 32'h730);
        bus.i_stall = 1'b0;
        tick();
        check("postflush_drain", bus.o_count, 0);

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Circular instruction buffer between the fetch/align stage and decode. Each cycle it accepts up to `FETCH_WIDTH` aligned instruction slots, compacting away invalid slots, and presents up to two in-order instructions to decode. It decouples fetch from decode back-pressure and drops its contents on pipeline flush.

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥4.
- `FETCH_WIDTH`, 2, slots per enqueue/dequeue; only 2 is supported, any other value raises an elaboration `$error`.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_flush`  in  1  synchronous clear of all entries.
- `i_valid`  in  1  upstream bundle present.
- `i_instrs`  in  `aligned_instr_t [0:FETCH_WIDTH-1]`  upstream slots; a slot is enqueued only if its `.valid` field is 1.
- `o_stall`  out  1  back-pressure to upstream.
- `i_stall`  in  1  decode not accepting this cycle.
- `o_valid`  out  1  at least one instruction presented.
- `o_instrs`  out  `aligned_instr_t [0:FETCH_WIDTH-1]`  presented instructions, head first.
- `o_count`  out  `$clog2(DEPTH)+1`  current occupancy.

## Operation
- State:
  - `head` and `tail` pointers, `$clog2(DEPTH)` bits each, wrapping modulo `DEPTH`.
  - `count`, `$clog2(DEPTH)+1` bits.
  - Entry array of `aligned_instr_t`.
- `o_stall = (DEPTH - count) < 2`. It is combinational from registered `count` only; it does not depend on same-cycle dequeue.
- Enqueue when `i_valid && !o_stall`:
  - `n_enq` = number of slots with `.valid` = 1 (0..2).
  - Slots are written at `tail`, `tail+1` in slot order, skipping invalid slots. Example: only slot 1 valid → slot 1 is written at `tail`.
  - `tail += n_enq`.
- Presentation (combinational from registered state):
  - `o_instrs[0]` = entry[`head`] if `count ≥ 1`, else `'0`.
  - `o_instrs[1]` = entry[`head+1`] if `count ≥ 2` and entry[`head`]`.except.valid == 0`, else `'0`. A faulting instruction always leaves alone.
  - `o_valid = (count != 0)`.
- Dequeue when `o_valid && !i_stall`:
  - `n_deq` = number of presented slots with `.valid` = 1.
  - `head += n_deq`.
- Count update: `count_next = count + n_enq - n_deq`. Simultaneous enqueue and dequeue is legal in the same cycle.
- Flush/reset: when `!i_rst_n || i_flush`, then `head = tail = count = 0` and entry contents are don't-care. This takes priority over the same-cycle enqueue and dequeue; the input bundle in that cycle is discarded.
- No full/empty ambiguity: occupancy is tracked by `count`, never by pointer equality.
- Overflow cannot occur because enqueue is gated by `o_stall`. An underflow attempt is impossible by construction, since `n_deq ≤ count`.

## Timing
- Reset values:
  - `o_valid = 0`.
  - `o_instrs = '0`.
  - `o_count = 0`.
  - `o_stall = 0`.
- Enqueue-to-output latency is 1 cycle: a slot written at edge N appears on `o_instrs` after edge N. There is no same-cycle bypass.
- Dequeue takes effect at the edge. The next instructions appear in the following cycle.
- `o_stall` asserts in the cycle after `count` reaches `DEPTH-1`; it stays asserted at `DEPTH` and deasserts the cycle after `count` drops to `DEPTH-2` or below.
- Upstream must hold its bundle while `o_stall` is asserted. The queue samples `i_instrs` only when `i_valid && !o_stall`.
- Flush: outputs are invalid in the cycle after the `i_flush` edge. A bundle presented in the cycle after that edge is accepted normally.

## Test plan
- Reset, then enqueue {pc `0x100` valid, pc `0x104` valid} with `i_stall=1` → the next cycle shows `o_count=2`, `o_valid=1`, `o_instrs[0].pc=0x100`, `o_instrs[1].pc=0x104`. Deassert `i_stall` for one cycle → `o_count=0`, `o_valid=0`.
- Enqueue {slot 0 invalid, slot 1 pc `0x204` valid} → `o_count=1`, `o_instrs[0].pc=0x204`, `o_instrs[1].valid=0`.
- Hold `i_stall=1` and enqueue full pairs with `DEPTH=8`:
  - after 3 pairs, `o_count=6` and `o_stall=0`;
  - after the 4th pair, `o_count=8` and `o_stall=1`, and further input is ignored.
  - Release `i_stall` → pops 2 per cycle in PC order; `o_stall` drops once `count ≤ 6`.
- Continuous enqueue of 2/cycle with `i_stall=0` for 20 cycles → `count` holds at 2 after the first cycle, PCs emerge in order, and the pointers wrap with no loss or duplication.
- Head entry with `except.valid=1` and `count=3` → only slot 0 is presented, then `count=2`. The next cycle presents two instructions.
- `i_flush` with `count=5`, asserted in the same cycle as an enqueue and a dequeue → next cycle `o_count=0`, `o_valid=0`, `o_stall=0`. An enqueue in the following cycle is accepted normally.
